// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the FSM state encoding, bus widths and the legal-length helper.
package fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 40;
  localparam int LEN_W   = 3;
  localparam int MAX_LEN = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_VALID,
    ST_HALTED,
    ST_FAULT
  } state_t;

  // A length of zero or anything beyond the longest encoding is an illegal instruction.
  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int max_len);
    return (len != '0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a byte-addressed instruction stream,
// presents one captured 5-byte window at a time to decode, and handles redirect/halt/fault.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0,
  parameter int                MAX_LEN  = fetch_pkg::MAX_LEN,
  parameter int                CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_pc,
  output logic [ADDR_W-1:0]   imem_pc,
  input  logic [INSTR_W-1:0]  imem_instr,
  output logic                fe_valid,
  output logic [ADDR_W-1:0]   fe_pc,
  output logic [INSTR_W-1:0]  fe_instr,
  input  logic                de_ready,
  input  logic [LEN_W-1:0]    de_len,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                halt_req,
  output logic                busy,
  output logic                fault,
  output logic [CNT_W-1:0]    fetch_count
);

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  pc, pc_nx;
  logic               load_fe;
  logic               count_inc;
  logic               legal;

  assign legal = len_legal(de_len, MAX_LEN);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Priority inside each state: redirect, then accept/fault, then halt, then start.
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    load_fe   = 1'b0;
    count_inc = 1'b0;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_nx    = start_pc;
          state_nx = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_nx    = redirect_pc;
          state_nx = ST_FETCH;
        end else if (halt_req) begin
          state_nx = ST_HALTED;
        end else begin
          load_fe  = 1'b1;
          state_nx = ST_VALID;
        end
      end
      ST_VALID: begin
        if (redirect_valid) begin
          pc_nx    = redirect_pc;
          state_nx = ST_FETCH;
        end else if (de_ready && !legal) begin
          state_nx = ST_FAULT;
        end else begin
          if (de_ready) begin
            pc_nx     = pc + ADDR_W'(de_len);
            count_inc = 1'b1;
            state_nx  = ST_FETCH;
          end
          if (halt_req) state_nx = ST_HALTED;
        end
      end
      ST_FAULT: state_nx = ST_FAULT;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // The presented window is only written on entry to VALID, so it stays stable until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      fe_pc       <= '0;
      fe_instr    <= '0;
      fetch_count <= '0;
    end else begin
      pc <= pc_nx;
      if (load_fe) begin
        fe_pc    <= pc;
        fe_instr <= imem_instr;
      end
      if (count_inc) fetch_count <= fetch_count + 1'b1;
    end
  end

  assign imem_pc  = pc;
  assign fe_valid = (state == ST_VALID);
  assign busy     = (state == ST_FETCH) || (state == ST_VALID);
  assign fault    = (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the fetch stream.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, de_ready, redirect_valid, halt_req;
  logic [31:0] start_pc, redirect_pc, imem_pc, fe_pc;
  logic [39:0] imem_instr, fe_instr;
  logic [2:0]  de_len;
  logic        fe_valid, busy, fault;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_PC(32'h0), .MAX_LEN(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .imem_pc(imem_pc), .imem_instr(imem_instr),
    .fe_valid(fe_valid), .fe_pc(fe_pc), .fe_instr(fe_instr),
    .de_ready(de_ready), .de_len(de_len),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .busy(busy), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory where byte[n] = n (low 8 bits of the address).
  function automatic logic [39:0] window(input logic [31:0] addr);
    logic [39:0] w;
    w = '0;
    for (int i = 0; i < 5; i++) w[i*8 +: 8] = 8'(addr + 32'(i));
    return w;
  endfunction

  assign imem_instr = window(imem_pc);

  // Reference model: where the stream is, whether an instruction is on offer, and what it is.
  typedef enum {M_IDLE, M_LOADING, M_OFFERED, M_HALTED, M_FAULT} mode_t;
  mode_t       mMode;
  logic [31:0] mPc, mFePc;
  logic [39:0] mFeInstr;
  int unsigned mCount;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    if (reset) begin
      mMode = M_IDLE; mPc = 32'h0; mCount = 0; mFePc = 32'h0; mFeInstr = '0;
    end else begin
      case (mMode)
        M_IDLE, M_HALTED:
          if (start) begin mPc = start_pc; mMode = M_LOADING; end
        M_LOADING:
          if (redirect_valid) mPc = redirect_pc;
          else if (halt_req) mMode = M_HALTED;
          else begin mFePc = mPc; mFeInstr = window(mPc); mMode = M_OFFERED; end
        M_OFFERED:
          if (redirect_valid) begin mPc = redirect_pc; mMode = M_LOADING; end
          else if (de_ready && (de_len == 0 || de_len > 5)) mMode = M_FAULT;
          else begin
            if (de_ready) begin mPc = mPc + 32'(de_len); mCount++; mMode = M_LOADING; end
            if (halt_req) mMode = M_HALTED;
          end
        default: ;
      endcase
    end
  endtask

  task automatic compareModel();
    checkOutput("fe_valid", 64'(fe_valid), 64'(mMode == M_OFFERED));
    checkOutput("busy", 64'(busy), 64'(mMode == M_LOADING || mMode == M_OFFERED));
    checkOutput("fault", 64'(fault), 64'(mMode == M_FAULT));
    checkOutput("fetch_count", 64'(fetch_count), 64'(mCount[15:0]));
    checkOutput("imem_pc", 64'(imem_pc), 64'(mPc));
    checkOutput("fe_pc", 64'(fe_pc), 64'(mFePc));
    checkOutput("fe_instr", 64'(fe_instr), 64'(mFeInstr));
  endtask

  task automatic applyStimulus(input bit r, input bit st, input logic [31:0] spc,
                               input bit rdy, input logic [2:0] len,
                               input bit rv, input logic [31:0] rpc, input bit h);
    reset = r; start = st; start_pc = spc; de_ready = rdy; de_len = len;
    redirect_valid = rv; redirect_pc = rpc; halt_req = h;
    modelStep();
    @(posedge clk);
    #1;
    compareModel();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; start = 0; start_pc = 0; de_ready = 0; de_len = 0;
    redirect_valid = 0; redirect_pc = 0; halt_req = 0;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_fe_valid", 64'(fe_valid), 64'd0);
    checkOutput("rst_imem_pc", 64'(imem_pc), 64'h0);

    // Start at 0, first instruction two cycles later
    applyStimulus(0, 1, 32'h0, 0, 0, 0, 0, 0);
    idle();
    checkOutput("start_fe_valid", 64'(fe_valid), 64'd1);
    checkOutput("start_fe_instr", 64'(fe_instr), 64'h0403020100);
    checkOutput("start_count", 64'(fetch_count), 64'd0);

    // Accept lengths 1 then 4
    applyStimulus(0, 0, 0, 1, 3'd1, 0, 0, 0);
    idle();
    checkOutput("acc1_fe_pc", 64'(fe_pc), 64'h1);
    checkOutput("acc1_fe_instr", 64'(fe_instr), 64'h0504030201);
    applyStimulus(0, 0, 0, 1, 3'd4, 0, 0, 0);
    idle();
    checkOutput("acc4_fe_pc", 64'(fe_pc), 64'h5);
    checkOutput("acc4_fe_instr", 64'(fe_instr), 64'h0908070605);
    checkOutput("acc4_count", 64'(fetch_count), 64'd2);

    // Redirect beats a same-cycle accept
    applyStimulus(0, 0, 0, 1, 3'd2, 1, 32'h10, 0);
    checkOutput("redir_drop_valid", 64'(fe_valid), 64'd0);
    idle();
    checkOutput("redir_fe_pc", 64'(fe_pc), 64'h10);
    checkOutput("redir_fe_instr", 64'(fe_instr), 64'h1413121110);
    checkOutput("redir_count", 64'(fetch_count), 64'd2);

    // Halt with a legal accept at pc=5, then resume at 0x20
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h5, 0);
    idle();
    applyStimulus(0, 0, 0, 1, 3'd3, 0, 0, 1);
    checkOutput("halt_count", 64'(fetch_count), 64'd3);
    checkOutput("halt_pc", 64'(imem_pc), 64'h8);
    checkOutput("halt_busy", 64'(busy), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h77, 0);
    checkOutput("halt_ignores_redir", 64'(imem_pc), 64'h8);
    applyStimulus(0, 1, 32'h20, 0, 0, 0, 0, 0);
    idle();
    checkOutput("resume_fe_instr", 64'(fe_instr), 64'h2423222120);

    // Reset in VALID with three accepted instructions
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midrst_count", 64'(fetch_count), 64'd0);
    checkOutput("midrst_valid", 64'(fe_valid), 64'd0);
    checkOutput("midrst_pc", 64'(imem_pc), 64'h0);

    // Illegal lengths 0 and 6 fault; start and redirect are ignored afterwards
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 1, 32'h0, 0, 0, 0, 0, 0);
      idle();
      applyStimulus(0, 0, 0, 1, (k == 0) ? 3'd0 : 3'd6, 0, 0, 0);
      checkOutput("fault_flag", 64'(fault), 64'd1);
      checkOutput("fault_count", 64'(fetch_count), 64'd0);
      applyStimulus(0, 1, 32'h40, 0, 0, 1, 32'h80, 0);
      checkOutput("fault_sticky", 64'(fault), 64'd1);
      checkOutput("fault_pc_held", 64'(imem_pc), 64'h0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    end

    // Randomized traffic, including resets with garbage inputs and pc wraparound
    for (int n = 0; n < 600; n++) begin
      bit          r, st, rdy, rv, h;
      logic [2:0]  len;
      logic [31:0] spc, rpc;
      r   = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rdy = $urandom_range(0, 1) == 1;
      rv  = ($urandom_range(0, 7) == 0);
      h   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 15) == 0) len = 3'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(6, 7));
      else                            len = 3'($urandom_range(1, 5));
      spc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      applyStimulus(r, st, spc, rdy, len, rv, rpc, h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters SHALL be: RESET_PC, 32'h0, PC value loaded at reset; MAX_LEN, 5, largest legal instruction length in bytes; CNT_W, 16, width of the fetch counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  begin fetching at start_pc; honoured in IDLE and HALTED only.
REQ-005 start_pc  input  32  initial or resume byte address.
REQ-006 imem_pc  output  32  byte address to instruction memory; equals the internal pc register.
REQ-007 imem_instr  input  40  combinational little-endian 5-byte window at imem_pc; byte at imem_pc is in [7:0].
REQ-008 fe_valid  output  1  fe_pc and fe_instr hold a fetched instruction.
REQ-009 fe_pc  output  32  address of the presented instruction.
REQ-010 fe_instr  output  40  captured window.
REQ-011 de_ready  input  1  decode accepts the presented instruction this cycle.
REQ-012 de_len  input  3  byte length of the accepted instruction; sampled only when fe_valid and de_ready are both high.
REQ-013 redirect_valid, redirect_pc  input  1, 32  branch or flush target.
REQ-014 halt_req  input  1  stop fetching after the current cycle.
REQ-015 busy  output  1  high in FETCH and VALID.
REQ-016 fault  output  1  sticky illegal-length indication.
REQ-017 fetch_count  output  CNT_W  number of accepted instructions since reset; wraps modulo 2^CNT_W.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, VALID, HALTED and FAULT.
REQ-019 IDLE: on start, pc <= start_pc and the FSM moves to FETCH; otherwise it holds.
REQ-020 FETCH: fe_instr <= imem_instr, fe_pc <= pc, and the FSM moves to VALID. Latency from pc load to fe_valid is exactly 1 cycle.
REQ-021 VALID: fe_valid = 1. fe_pc and fe_instr SHALL remain stable until accept, redirect or reset.
REQ-022 Accept (VALID and de_ready) with 1 <= de_len <= MAX_LEN: pc <= pc + de_len (modulo 2^32), fetch_count increments, and the FSM moves to FETCH. Throughput is 1 instruction per 2 cycles.
REQ-023 Accept with de_len = 0 or de_len > MAX_LEN: the FSM moves to FAULT, fault = 1, pc and fetch_count are unchanged.
REQ-024 Redirect in FETCH or VALID: pc <= redirect_pc, the FSM moves to FETCH, and fe_valid drops the next cycle.
    - Redirect overrides any accept in the same cycle; no count increment.
    - Redirect is ignored in IDLE, HALTED and FAULT.
REQ-025 halt_req in FETCH or VALID without redirect: the FSM moves to HALTED.
    - A simultaneous legal accept still completes: pc advances and the count increments.
    - A simultaneous illegal accept goes to FAULT instead.
REQ-026 HALTED: fe_valid = 0 and pc is held. start reloads pc from start_pc and moves to FETCH.
REQ-027 FAULT: fe_valid = 0 and busy = 0. The state is exited only by reset.
REQ-028 Priority SHALL be reset > redirect > accept/fault > halt_req > start.
REQ-029 fe_valid SHALL be asserted only in VALID.

Reset
REQ-030 Reset SHALL be synchronous and active-high, and SHALL take effect on any rising edge with reset high, including mid-operation.
REQ-031 Reset values SHALL be: state IDLE; pc and imem_pc RESET_PC; fe_pc 0; fe_instr 0; fe_valid 0; busy 0; fault 0; fetch_count 0.
REQ-032 Inputs SHALL be ignored while reset is high.

Structure
REQ-033 A shared package fetch_pkg SHALL hold the state enum, MAX_LEN, the instruction window width (40) and the address width (32).
REQ-034 No sub-module SHALL be used. The instr_mem instance belongs to the parent, and fetch_ctrl connects to it only through imem_pc and imem_instr.

Verification
All scenarios use an instr_mem loaded so that byte[n] = n.
REQ-035 Reset, then start with start_pc=0 -> two cycles later fe_valid=1, fe_pc=0, fe_instr=40'h0403020100, fetch_count=0.
REQ-036 Accept de_len=1, then accept de_len=4 -> fe_pc=1 with fe_instr=40'h0504030201, then fe_pc=5 with fe_instr=40'h0908070605; fetch_count=2.
REQ-037 In VALID, redirect_valid with redirect_pc=0x10 and de_ready/de_len=2 in the same cycle -> fe_pc=0x10, fe_instr=40'h1413121110, fetch_count unchanged.
REQ-038 Accept with de_len=0 (and separately de_len=6) -> fault=1, state FAULT, fe_valid=0; start and redirect ignored until reset.
REQ-039 halt_req together with a legal accept de_len=3 at pc=5 -> HALTED, fetch_count incremented, pc=8; then start with start_pc=0x20 -> fe_instr=40'h2423222120.
REQ-040 Reset asserted in VALID with fetch_count=3 -> next cycle state IDLE, fe_valid=0, fetch_count=0, imem_pc=RESET_PC.
